mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache controller and the data-cache controller.
- Grants one requester at a time for a whole writeback/allocate burst, with round-robin fairness.
- Forwards beats to memory and tags every accepted read, so returning read data is steered to the requester that issued it, even after ownership has moved.
- Sits between both cache FSMs and the four-banked memory.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles from an accepted mem_rd to valid mem_rdata (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  I-cache requests ownership; held for the whole burst
- i_rd  in  1  I-cache read beat
- i_wr  in  1  I-cache write beat
- i_addr  in  ADDR_W  I-cache beat address
- i_wdata  in  DATA_W  I-cache write data
- i_gnt  out  1  I-cache owns the memory port
- i_stall  out  1  I-cache beat not accepted this cycle
- i_rdata  out  DATA_W  read data to I-cache
- i_rvalid  out  1  i_rdata valid
- d_req, d_rd, d_wr, d_addr, d_wdata, d_gnt, d_stall, d_rdata, d_rvalid: same as the i_ ports, for the D-cache
- mem_rd  out  1  read to memory
- mem_wr  out  1  write to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_stall  in  1  memory rejects this cycle's beat (bank busy)
- mem_rdata  in  DATA_W  memory read data
- err  out  1  protocol error

Behaviour:
Reset (rst=0, async):
- state=IDLE; last_owner=I; tag pipeline cleared.
- All outputs 0, except i_stall and d_stall, which follow the stall rule below.
- Reads in flight are discarded.

Grant FSM, registered:
- States: IDLE, OWN_I, OWN_D. gnt outputs decode the state.
- IDLE, one req high: go to its OWN state next cycle.
- IDLE, both high: go to the requester that is not last_owner. First arbitration after reset grants D.
- OWN_x with x_req=1: stay. No preemption and no timeout.
- OWN_x with x_req=0: arbitrate exactly as from IDLE in the same cycle, so back-to-back handoff has no bubble. The other requester wins if its req is high; otherwise go to IDLE. last_owner<=x.
- Request-to-grant latency: 1 cycle minimum.

Beat forwarding, combinational from the owner only:
- mem_rd=own_rd, mem_wr=own_wr, mem_addr=own_addr, mem_wdata=own_wdata.
- Non-owner beats are never forwarded. In IDLE, mem_rd=mem_wr=0 and mem_addr=mem_wdata=0.
- Owner x: x_stall=mem_stall.
- Non-owner x: x_stall = x_rd|x_wr. Also 1 whenever x_gnt=0 and x_req=1.
- Owner with rd&wr both high: err=1 that cycle, mem_rd=mem_wr=0, x_stall=1. err is combinational and has no other source.
- A beat is accepted when (mem_rd|mem_wr) & ~mem_stall.

Read tagging:
- Shift register of MEM_LAT entries {valid, owner}, shifting every cycle.
- Entry 0 gets {mem_rd & ~mem_stall, current owner}.
- When the tail entry is valid: the tagged requester gets rvalid=1 and rdata=mem_rdata. The other requester gets rvalid=0 and rdata=0.
- A tag keeps its owner after grant handoff, so reads still draining route correctly while the new owner issues beats.
- Stalled beats create no tag.
- Write beats create no tag and give no response.

Boundaries:
- Owner drops req on the same edge as its last accepted read: grant passes, and the data still returns to the old owner MEM_LAT cycles later.
- Both req high continuously: grants alternate per burst (D, I, D, ...).
- req high with no rd/wr: the port is held idle; legal.
- Reset asserted mid-burst: immediate IDLE; no rvalid after release until new reads are accepted.

Test Plan:
- Reset, then i_req=1 alone → i_gnt=1 next cycle; i_rd with addr 0x1230 → mem_rd=1, mem_addr=0x1230; mem_rdata=0xBEEF after 2 cycles → i_rvalid=1, i_rdata=0xBEEF, d_rvalid=0.
- i_req and d_req rise together after reset → d_gnt first. d_req drops → i_gnt the very next cycle, no IDLE cycle. Both held continuously → grants alternate over 4 bursts.
- D owner issues 4 read beats, mem_stall=1 on beat 2 for 3 cycles → d_stall mirrors mem_stall, exactly 4 tags, 4 d_rvalid pulses in issue order.
- D issues its last read and drops d_req on the same edge; I is granted and writes 0x00FF to 0x4000 → mem_wr=1, mem_wdata=0x00FF; d_rvalid pulses 2 cycles after the last read; i_rvalid stays 0.
- Non-owner I asserts i_rd while D owns → i_stall=1, mem_addr stays D's.
- Owner asserts rd&wr → err=1, mem_rd=mem_wr=0.
- rst pulled low with 2 reads in flight → all gnt/rvalid=0 immediately; after release, no rvalid appears.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: both cache requester ports plus the shared memory port
interface mem_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
    logic              i_req, i_rd, i_wr, i_gnt, i_stall, i_rvalid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata, i_rdata;
    logic              d_req, d_rd, d_wr, d_gnt, d_stall, d_rvalid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_rd, mem_wr, mem_stall, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  i_req, i_rd, i_wr, i_addr, i_wdata, d_req, d_rd, d_wr, d_addr, d_wdata, mem_stall, mem_rdata,
        output i_gnt, i_stall, i_rdata, i_rvalid, d_gnt, d_stall, d_rdata, d_rvalid,
        output mem_rd, mem_wr, mem_addr, mem_wdata, err
    );
    modport master (
        output i_req, i_rd, i_wr, i_addr, i_wdata, d_req, d_rd, d_wr, d_addr, d_wdata, mem_stall, mem_rdata,
        input  i_gnt, i_stall, i_rdata, i_rvalid, d_gnt, d_stall, d_rdata, d_rvalid,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin burst owner of the memory port with tagged read returns
module mem_arbiter #(parameter int MEM_LAT = 2) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2;
    logic [1:0]         state, state_nx;
    logic               last_d, prev_d, own_i, own_d, free, o_rd, o_wr, conflict, tail_v, tail_d;
    logic [MEM_LAT-1:0] tag_v, tag_d;
    assign own_i  = state == OWN_I;
    assign own_d  = state == OWN_D;
    // a finishing owner counts as the last owner in the same-cycle arbitration
    assign prev_d = own_d | (state == IDLE & last_d);
    assign free   = state == IDLE | (own_i & ~bus.i_req) | (own_d & ~bus.d_req);
    // round-robin pick whenever the port is free, favouring the requester that did not own it last
    always_comb begin
        state_nx = state;
        if (free)
            state_nx = (bus.i_req & bus.d_req) ? (prev_d ? OWN_I : OWN_D) :
                       bus.i_req ? OWN_I : bus.d_req ? OWN_D : IDLE;
    end
    // grant state and round-robin history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nx;
            last_d <= prev_d;
        end
    end
    // read tags travel alongside the memory latency and keep the issuing owner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v <= '0;
            tag_d <= '0;
        end else begin
            for (int k = MEM_LAT - 1; k > 0; k--) begin
                tag_v[k] <= tag_v[k-1];
                tag_d[k] <= tag_d[k-1];
            end
            tag_v[0] <= bus.mem_rd & ~bus.mem_stall;
            tag_d[0] <= own_d;
        end
    end
    assign o_rd          = own_i ? bus.i_rd : own_d & bus.d_rd;
    assign o_wr          = own_i ? bus.i_wr : own_d & bus.d_wr;
    assign conflict      = o_rd & o_wr;
    assign bus.err       = conflict;
    assign bus.mem_rd    = o_rd & ~conflict;
    assign bus.mem_wr    = o_wr & ~conflict;
    assign bus.mem_addr  = own_i ? bus.i_addr : own_d ? bus.d_addr : '0;
    assign bus.mem_wdata = own_i ? bus.i_wdata : own_d ? bus.d_wdata : '0;
    assign bus.i_gnt     = own_i;
    assign bus.d_gnt     = own_d;
    assign bus.i_stall   = own_i ? bus.mem_stall | conflict : bus.i_rd | bus.i_wr | bus.i_req;
    assign bus.d_stall   = own_d ? bus.mem_stall | conflict : bus.d_rd | bus.d_wr | bus.d_req;
    assign tail_v        = tag_v[MEM_LAT-1];
    assign tail_d        = tag_d[MEM_LAT-1];
    assign bus.i_rvalid  = tail_v & ~tail_d;
    assign bus.d_rvalid  = tail_v & tail_d;
    assign bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-vector table plus a continuous-request alternation sequence
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;
    int   n;
    always #5 clk = ~clk;
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();
    mem_arbiter #(.MEM_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    // ef = {i_gnt,d_gnt,i_stall,d_stall,i_rvalid,d_rvalid,mem_rd,mem_wr,err}; ic/dc = {req,rd,wr}
    typedef struct {
        logic        r;
        logic [2:0]  ic, dc;
        logic [15:0] ia, iw, da, dw;
        logic        ms;
        logic [15:0] mrd;
        logic [8:0]  ef;
        logic [15:0] eir, edr, ema, emw;
    } vec_t;
    vec_t tv[$];
    task automatic add(input logic r, input logic [2:0] ic, dc, input logic [15:0] ia, iw, da, dw,
                       input logic ms, input logic [15:0] mrd, input logic [8:0] ef,
                       input logic [15:0] eir, edr, ema, emw);
        tv.push_back('{r, ic, dc, ia, iw, da, dw, ms, mrd, ef, eir, edr, ema, emw});
    endtask
    task automatic chk(input string nm, input int idx, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s #%0d: got %h want %h", nm, idx, a, e);
        end
    endtask
    initial begin
        {bus.i_req, bus.i_rd, bus.i_wr, bus.d_req, bus.d_rd, bus.d_wr, bus.mem_stall} = '0;
        {bus.i_addr, bus.i_wdata, bus.d_addr, bus.d_wdata, bus.mem_rdata} = '0;
        // reset state, then I alone: grant, read 0x1230, data back two cycles later
        add(0, 3'b000, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b000000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(0, 3'b100, 3'b000, 16'h1230, 16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b001000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b100, 3'b000, 16'h1230, 16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b001000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b110, 3'b000, 16'h1230, 16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b100000100, 16'h0,    16'h0,    16'h1230, 16'h0);
        add(1, 3'b100, 3'b000, 16'h1230, 16'h0,    16'h0,    16'h0,    0, 16'h1111, 9'b100000000, 16'h0,    16'h0,    16'h1230, 16'h0);
        add(1, 3'b100, 3'b000, 16'h1230, 16'h0,    16'h0,    16'h0,    0, 16'hBEEF, 9'b100010000, 16'hBEEF, 16'h0,    16'h1230, 16'h0);
        add(1, 3'b000, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b100000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b000, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b000000000, 16'h0,    16'h0,    16'h0,    16'h0);
        // both request: D first, then bubble-free handoffs D, I, D, I, then idle
        add(1, 3'b100, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b001100000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b100, 3'b101, 16'h0,    16'h0,    16'h2000, 16'h5555, 0, 16'h0,    9'b011000010, 16'h0,    16'h0,    16'h2000, 16'h5555);
        add(1, 3'b100, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b011000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b100, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b100100000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b000, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b100100000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b100, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b011000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b100, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b011000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b100, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b100100000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b000, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b100000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b000, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b000000000, 16'h0,    16'h0,    16'h0,    16'h0);
        // D reads four beats, beat 2 stalled three cycles; responses in issue order
        add(1, 3'b000, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b000100000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0100, 16'h0,    0, 16'h0,    9'b010000100, 16'h0,    16'h0,    16'h0100, 16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0101, 16'h0,    1, 16'h0,    9'b010100100, 16'h0,    16'h0,    16'h0101, 16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0101, 16'h0,    1, 16'hA001, 9'b010101100, 16'h0,    16'hA001, 16'h0101, 16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0101, 16'h0,    1, 16'h0,    9'b010100100, 16'h0,    16'h0,    16'h0101, 16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0101, 16'h0,    0, 16'h0,    9'b010000100, 16'h0,    16'h0,    16'h0101, 16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0102, 16'h0,    0, 16'h0,    9'b010000100, 16'h0,    16'h0,    16'h0102, 16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0103, 16'h0,    0, 16'hA002, 9'b010001100, 16'h0,    16'hA002, 16'h0103, 16'h0);
        add(1, 3'b000, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'hA003, 9'b010001000, 16'h0,    16'hA003, 16'h0,    16'h0);
        add(1, 3'b000, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'hA004, 9'b010001000, 16'h0,    16'hA004, 16'h0,    16'h0);
        add(1, 3'b000, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b010000000, 16'h0,    16'h0,    16'h0,    16'h0);
        // D's last read with req dropped; I writes 0x00FF to 0x4000 while D's data drains
        add(1, 3'b100, 3'b010, 16'h0,    16'h0,    16'h0200, 16'h0,    0, 16'h0,    9'b011000100, 16'h0,    16'h0,    16'h0200, 16'h0);
        add(1, 3'b101, 3'b000, 16'h4000, 16'h00FF, 16'h0,    16'h0,    0, 16'h0,    9'b100000010, 16'h0,    16'h0,    16'h4000, 16'h00FF);
        add(1, 3'b100, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'hC0DE, 9'b100001000, 16'h0,    16'hC0DE, 16'h0,    16'h0);
        // non-owner I read is stalled, owner rd&wr flags err, reset with two reads in flight
        add(1, 3'b000, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'h0,    9'b100100000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b010, 3'b110, 16'h7777, 16'h0,    16'h0300, 16'h0,    0, 16'h0,    9'b011000100, 16'h0,    16'h0,    16'h0300, 16'h0);
        add(1, 3'b000, 3'b111, 16'h0,    16'h0,    16'h0301, 16'h1234, 0, 16'h0,    9'b010100001, 16'h0,    16'h0,    16'h0301, 16'h1234);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0302, 16'h0,    0, 16'hD001, 9'b010001100, 16'h0,    16'hD001, 16'h0302, 16'h0);
        add(1, 3'b000, 3'b110, 16'h0,    16'h0,    16'h0303, 16'h0,    0, 16'h0,    9'b010000100, 16'h0,    16'h0,    16'h0303, 16'h0);
        add(0, 3'b000, 3'b100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'hEEEE, 9'b000100000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b000, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'hEEEE, 9'b000000000, 16'h0,    16'h0,    16'h0,    16'h0);
        add(1, 3'b000, 3'b000, 16'h0,    16'h0,    16'h0,    16'h0,    0, 16'hEEEE, 9'b000000000, 16'h0,    16'h0,    16'h0,    16'h0);
        foreach (tv[v]) begin
            @(negedge clk);
            rst = tv[v].r;
            {bus.i_req, bus.i_rd, bus.i_wr} = tv[v].ic;
            {bus.d_req, bus.d_rd, bus.d_wr} = tv[v].dc;
            bus.i_addr    = tv[v].ia;
            bus.i_wdata   = tv[v].iw;
            bus.d_addr    = tv[v].da;
            bus.d_wdata   = tv[v].dw;
            bus.mem_stall = tv[v].ms;
            bus.mem_rdata = tv[v].mrd;
            #1;
            chk("flags", v, 64'({bus.i_gnt, bus.d_gnt, bus.i_stall, bus.d_stall, bus.i_rvalid, bus.d_rvalid,
                                 bus.mem_rd, bus.mem_wr, bus.err}), 64'(tv[v].ef));
            chk("rdata", v, 64'({bus.i_rdata, bus.d_rdata}), 64'({tv[v].eir, tv[v].edr}));
            chk("mem", v, 64'({bus.mem_addr, bus.mem_wdata}), 64'({tv[v].ema, tv[v].emw}));
        end
        // fresh reset, both requests held; each owner ends its burst by dropping req for one cycle
        @(negedge clk);
        rst = 1'b0;
        {bus.i_rd, bus.i_wr, bus.d_rd, bus.d_wr, bus.mem_stall} = '0;
        @(negedge clk);
        rst = 1'b1;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        #1;
        for (int b = 0; b < 4; b++) begin
            n = 0;
            while (!(bus.i_gnt | bus.d_gnt) && n < 3) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("alternate", b, 64'({bus.i_gnt, bus.d_gnt}), b[0] ? 64'd2 : 64'd1);
            @(negedge clk);
            if (bus.d_gnt) bus.d_req = 1'b0;
            else bus.i_req = 1'b0;
            @(negedge clk);
            bus.i_req = 1'b1;
            bus.d_req = 1'b1;
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
